data_memory_stack: RTL and testbench

//   Parametrised data memory with an integrated hardware stack pointer. Serves

---
 rtl/data_memory_stack_if.sv | 27 ++
 rtl/data_memory_stack.sv | 134 +++++++++++++
 tb/tb_data_memory_stack.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_stack_if.sv
// Operation/response bundle for data_memory_stack; master drives ops, slave returns read data and stack status.
interface data_memory_stack_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              op_valid;
    logic [2:0]        op;
    logic              sel_rn;
    logic [ADDR_W-1:0] ptr_in;
    logic [DATA_W-1:0] npc_in;
    logic [DATA_W-1:0] rn_in;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [ADDR_W-1:0] sp_out;
    logic              stk_ovf;
    logic              stk_unf;

    modport master (
        output op_valid, op, sel_rn, ptr_in, npc_in, rn_in,
        input  data_out, data_valid, sp_out, stk_ovf, stk_unf
    );

    modport slave (
        input  op_valid, op, sel_rn, ptr_in, npc_in, rn_in,
        output data_out, data_valid, sp_out, stk_ovf, stk_unf
    );
endinterface

// File: rtl/data_memory_stack.sv
// Data memory with built-in downward stack pointer: LOAD/POP data one cycle later, one op per cycle, never stalls.
// Optional STACK_LIMIT_EN macro adds a depth counter that rejects PUSH when full and POP when empty.
module data_memory_stack #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] SP_RESET    = {ADDR_W{1'b1}},
    parameter int                STACK_DEPTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_stack_if.slave  bus
);
    localparam logic [2:0] OP_LOAD  = 3'd1;
    localparam logic [2:0] OP_STORE = 3'd2;
    localparam logic [2:0] OP_PUSH  = 3'd3;
    localparam logic [2:0] OP_POP   = 3'd4;

    if (STACK_DEPTH < 1 || STACK_DEPTH > 2**ADDR_W) begin : g_depth_chk
        $error("data_memory_stack: STACK_DEPTH out of range");
    end

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    logic [ADDR_W-1:0] sp_q, sp_d, sp_inc;
    logic [DATA_W-1:0] data_out_q, wdata;
    logic              data_valid_q;
    logic              mem_we, rd_en;
    logic [ADDR_W-1:0] mem_waddr, rd_addr;

`ifdef STACK_LIMIT_EN
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               ovf_q, ovf_d, unf_q, unf_d;
`endif

    always_comb begin
        wdata     = bus.sel_rn ? bus.rn_in : bus.npc_in;
        sp_inc    = sp_q + ADDR_W'(1);
        sp_d      = sp_q;
        mem_we    = 1'b0;
        mem_waddr = bus.ptr_in;
        rd_en     = 1'b0;
        rd_addr   = bus.ptr_in;
`ifdef STACK_LIMIT_EN
        depth_d   = depth_q;
        ovf_d     = 1'b0;
        unf_d     = 1'b0;
`endif
        if (bus.op_valid) begin
            case (bus.op)
                OP_LOAD:  rd_en  = 1'b1;
                OP_STORE: mem_we = 1'b1;
                OP_PUSH: begin
`ifdef STACK_LIMIT_EN
                    if (depth_q == DEPTH_W'(STACK_DEPTH)) begin
                        ovf_d = 1'b1;
                    end else begin
                        mem_we    = 1'b1;
                        mem_waddr = sp_q;
                        sp_d      = sp_q - ADDR_W'(1);
                        depth_d   = depth_q + DEPTH_W'(1);
                    end
`else
                    mem_we    = 1'b1;
                    mem_waddr = sp_q;
                    sp_d      = sp_q - ADDR_W'(1);
`endif
                end
                OP_POP: begin
`ifdef STACK_LIMIT_EN
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        rd_en   = 1'b1;
                        rd_addr = sp_inc;
                        sp_d    = sp_inc;
                        depth_d = depth_q - DEPTH_W'(1);
                    end
`else
                    rd_en   = 1'b1;
                    rd_addr = sp_inc;
                    sp_d    = sp_inc;
`endif
                end
                default: ;
            endcase
        end
    end

    // Storage is never reset; a write coinciding with rst is dropped.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            mem_q[mem_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q         <= SP_RESET;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            sp_q         <= sp_d;
            data_valid_q <= rd_en;
            if (rd_en) begin
                data_out_q <= mem_q[rd_addr];
            end
        end
    end

`ifdef STACK_LIMIT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.stk_ovf = ovf_q;
    assign bus.stk_unf = unf_q;
`else
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
`endif

    assign bus.data_out   = data_out_q;
    assign bus.data_valid = data_valid_q;
    assign bus.sp_out     = sp_q;
endmodule

// File: tb/tb_data_memory_stack.sv
// Directed bench for data_memory_stack: reference model of memory plus stack, per-cycle compare and hand-pinned values.
module tb_data_memory_stack;
`ifdef STACK_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif
    localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, STORE = 3'd2, PUSH = 3'd3, POP = 3'd4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_stack_if #(.DATA_W(8), .ADDR_W(8)) bus ();

    data_memory_stack #(.DATA_W(8), .ADDR_W(8), .STACK_DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Reference model state
    logic [7:0] m_mem   [256];
    bit         m_known [256];
    int         m_sp, m_depth;
    logic [7:0] m_dout;
    bit         m_dout_known, m_dv, m_ovf, m_unf;

    // Hand-computed pins, consumed by the compare process
    bit         chk_on, lit_en, lit_dchk;
    string      lit_name;
    logic [7:0] lit_sp, lit_dout;
    bit         lit_dv, lit_ovf, lit_unf;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("data_valid", 32'(bus.data_valid), 32'(m_dv));
            chk("sp_out", 32'(bus.sp_out), 32'(m_sp));
            chk("stk_ovf", 32'(bus.stk_ovf), 32'(m_ovf));
            chk("stk_unf", 32'(bus.stk_unf), 32'(m_unf));
            if (m_dout_known) chk("data_out", 32'(bus.data_out), 32'(m_dout));
            if (lit_en) begin
                chk({lit_name, ".sp"}, 32'(bus.sp_out), 32'(lit_sp));
                chk({lit_name, ".dv"}, 32'(bus.data_valid), 32'(lit_dv));
                chk({lit_name, ".ovf"}, 32'(bus.stk_ovf), 32'(lit_ovf));
                chk({lit_name, ".unf"}, 32'(bus.stk_unf), 32'(lit_unf));
                if (lit_dchk) chk({lit_name, ".dout"}, 32'(bus.data_out), 32'(lit_dout));
            end
        end
    end

    task automatic model_step();
        logic [7:0] wd;
        int a;
        wd = bus.sel_rn ? bus.rn_in : bus.npc_in;
        a  = int'(bus.ptr_in);
        m_dv = 0; m_ovf = 0; m_unf = 0;
        if (rst) begin
            m_sp = 255; m_depth = 0; m_dout = 8'h00; m_dout_known = 1;
            return;
        end
        if (!bus.op_valid) return;
        case (bus.op)
            LOAD: begin
                m_dout = m_mem[a]; m_dout_known = m_known[a]; m_dv = 1;
            end
            STORE: begin
                m_mem[a] = wd; m_known[a] = 1;
            end
            PUSH: begin
                if (LIM && m_depth == 16) m_ovf = 1;
                else begin
                    m_mem[m_sp] = wd; m_known[m_sp] = 1;
                    m_sp = (m_sp + 255) % 256; m_depth++;
                end
            end
            POP: begin
                if (LIM && m_depth == 0) m_unf = 1;
                else begin
                    m_sp = (m_sp + 1) % 256;
                    m_dout = m_mem[m_sp]; m_dout_known = m_known[m_sp]; m_dv = 1;
                    m_depth--;
                end
            end
            default: ;
        endcase
    endtask

    task automatic cyc(input bit r, input bit v, input logic [2:0] o, input bit sel,
                       input logic [7:0] ptr, input logic [7:0] npc, input logic [7:0] rn);
        @(negedge clk);
        #1;
        lit_en = 0;
        rst = r; bus.op_valid = v; bus.op = o; bus.sel_rn = sel;
        bus.ptr_in = ptr; bus.npc_in = npc; bus.rn_in = rn;
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic op1(input logic [2:0] o, input logic [7:0] ptr, input logic [7:0] rn);
        cyc(0, 1, o, 1, ptr, 8'hC3, rn);
    endtask

    task automatic pin(input string nm, input logic [7:0] sp, input bit dv, input bit ovf,
                       input bit unf, input bit dchk, input logic [7:0] dout);
        lit_name = nm; lit_sp = sp; lit_dv = dv; lit_ovf = ovf; lit_unf = unf;
        lit_dchk = dchk; lit_dout = dout; lit_en = 1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_known[i] = 0;
        chk_on = 0; lit_en = 0;
        bus.op_valid = 0; bus.op = NOP; bus.sel_rn = 0;
        bus.ptr_in = 0; bus.npc_in = 0; bus.rn_in = 0;

        cyc(1, 0, NOP, 0, 0, 0, 0);
        cyc(1, 0, NOP, 0, 0, 0, 0);
        chk_on = 1;
        pin("reset", 8'hFF, 0, 0, 0, 1, 8'h00);

        // Seed mem[00] so the unguarded POP-after-reset has a known result
        op1(STORE, 8'h00, 8'h5A);
        cyc(1, 1, NOP, 0, 0, 0, 0);
        op1(POP, 8'h00, 8'h00);
        if (LIM) pin("pop_empty", 8'hFF, 0, 0, 1, 1, 8'h00);
        else     pin("pop_wrap", 8'h00, 1, 0, 0, 1, 8'h5A);
        cyc(0, 0, NOP, 0, 0, 0, 0);
        cyc(1, 0, NOP, 0, 0, 0, 0);

        op1(STORE, 8'h10, 8'hA5);
        pin("store", 8'hFF, 0, 0, 0, 1, 8'h00);
        op1(LOAD, 8'h10, 8'h00);
        pin("load", 8'hFF, 1, 0, 0, 1, 8'hA5);

        cyc(0, 1, PUSH, 0, 8'h00, 8'h3C, 8'hEE);
        pin("push_npc", 8'hFE, 0, 0, 0, 0, 8'h00);
        op1(POP, 8'h00, 8'h00);
        pin("pop_npc", 8'hFF, 1, 0, 0, 1, 8'h3C);

        op1(PUSH, 8'h00, 8'h11);
        op1(PUSH, 8'h00, 8'h22);
        op1(PUSH, 8'h00, 8'h33);
        pin("push3", 8'hFC, 0, 0, 0, 0, 8'h00);
        op1(POP, 8'h00, 8'h00);
        pin("pop_33", 8'hFD, 1, 0, 0, 1, 8'h33);
        op1(POP, 8'h00, 8'h00);
        pin("pop_22", 8'hFE, 1, 0, 0, 1, 8'h22);
        op1(POP, 8'h00, 8'h00);
        pin("pop_11", 8'hFF, 1, 0, 0, 1, 8'h11);

        cyc(0, 1, PUSH, 1, 8'h00, 8'h01, 8'h5C);
        op1(POP, 8'h00, 8'h00);
        pin("sel_rn", 8'hFF, 1, 0, 0, 1, 8'h5C);

        // Non-ops: op 5-7 and an unaccepted PUSH leave everything but data_valid alone
        op1(3'd7, 8'h10, 8'h99);
        pin("op7", 8'hFF, 0, 0, 0, 1, 8'h5C);
        cyc(0, 0, PUSH, 1, 8'h00, 8'h00, 8'h99);
        pin("no_valid", 8'hFF, 0, 0, 0, 1, 8'h5C);

        op1(STORE, 8'hEF, 8'h77);
        for (int i = 0; i < 16; i++) op1(PUSH, 8'h00, 8'(8'h40 + i));
        pin("push16", 8'hEF, 0, 0, 0, 0, 8'h00);
        op1(PUSH, 8'h00, 8'hEE);
        if (LIM) pin("push_full", 8'hEF, 0, 1, 0, 0, 8'h00);
        else     pin("push17", 8'hEE, 0, 0, 0, 0, 8'h00);
        op1(LOAD, 8'hEF, 8'h00);
        if (LIM) pin("ovf_nowrite", 8'hEF, 1, 0, 0, 1, 8'h77);
        else     pin("push17_wrote", 8'hEE, 1, 0, 0, 1, 8'hEE);
        op1(POP, 8'h00, 8'h00);
        if (LIM) pin("pop_after_full", 8'hF0, 1, 0, 0, 1, 8'h4F);
        else     pin("pop_after_17", 8'hEF, 1, 0, 0, 1, 8'hEE);
        cyc(1, 0, NOP, 0, 0, 0, 0);

        op1(STORE, 8'h20, 8'h99);
        op1(PUSH, 8'h00, 8'h12);
        cyc(1, 1, STORE, 1, 8'h20, 8'h00, 8'h11);
        pin("rst_op", 8'hFF, 0, 0, 0, 1, 8'h00);
        op1(LOAD, 8'h20, 8'h00);
        pin("rst_nowrite", 8'hFF, 1, 0, 0, 1, 8'h99);

        op1(STORE, 8'h30, 8'hB7);
        op1(LOAD, 8'h30, 8'h00);
        op1(NOP, 8'h00, 8'h00);
        pin("hold", 8'hFF, 0, 0, 0, 1, 8'hB7);

        cyc(0, 0, NOP, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
